slice_vector: RTL and testbench



---
 rtl/slice_vector.sv | 222 ++++++++++++++++++++++
 tb/tb_slice_vector.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/slice_vector.sv
// slice_vector: per-frame katana history and iterative CORDIC heading.
// Build with SLICE_VECTOR_SWIPE_EN to expose raw magnitude and swipe flag.
module slice_vector #(
   parameter int X_W          = 11,
   parameter int Y_W          = 10,
   parameter int DEPTH        = 10,
   parameter int ANGLE_W      = 16,
   parameter int ITER         = 12,
   parameter int FRAME_H      = 1024,
   parameter int FRAME_V      = 768,
   parameter int SWIPE_THRESH = 64
) (
   input  logic               pixel_clk_in,
   input  logic               rst_n_in,
   input  logic [10:0]        hcount_in,
   input  logic [9:0]         vcount_in,
   input  logic [X_W-1:0]     katana_x,
   input  logic [Y_W-1:0]     katana_y,
   output logic [ANGLE_W-1:0] angle_out,
   output logic               angle_valid_out,
   output logic               busy_out,
   output logic               primed_out,
   output logic [X_W+2:0]     mag_out,
   output logic               swipe_out
);

   localparam int W  = X_W + 3;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int IW = $clog2(ITER + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_PREP = 2'd1;
   localparam logic [1:0] S_ITER = 2'd2;

   // atan(2^-i) as a fraction of a full turn, scaled by 2^32
   function automatic logic [31:0] atan32(input int i);
      case (i)
         0:  return 32'd536870912;
         1:  return 32'd316933406;
         2:  return 32'd167458907;
         3:  return 32'd85004756;
         4:  return 32'd42667331;
         5:  return 32'd21354465;
         6:  return 32'd10679838;
         7:  return 32'd5340245;
         8:  return 32'd2670163;
         9:  return 32'd1335087;
         10: return 32'd667544;
         11: return 32'd333772;
         12: return 32'd166886;
         13: return 32'd83443;
         14: return 32'd41722;
         15: return 32'd20861;
         16: return 32'd10430;
         17: return 32'd5215;
         18: return 32'd2608;
         19: return 32'd1304;
         20: return 32'd652;
         21: return 32'd326;
         22: return 32'd163;
         23: return 32'd81;
         24: return 32'd41;
         25: return 32'd20;
         26: return 32'd10;
         27: return 32'd5;
         28: return 32'd3;
         29: return 32'd1;
         30: return 32'd1;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [ANGLE_W-1:0] atan_ang(input int i);
      logic [63:0] t;
      t = ({32'd0, atan32(i)} << ANGLE_W) + 64'h8000_0000;
      return t[32 +: ANGLE_W];
   endfunction

   logic [X_W-1:0]     r_hx [DEPTH];
   logic [Y_W-1:0]     r_hy [DEPTH];
   logic [CW-1:0]      r_fill;
   logic [1:0]         r_state;
   logic [IW-1:0]      r_i;
   logic signed [W-1:0] r_x;
   logic signed [W-1:0] r_y;
   logic [ANGLE_W-1:0] r_z;
   logic               r_zero;
   logic [ANGLE_W-1:0] r_angle;
   logic               r_valid;

   logic               w_frame_done;
   logic               w_full_next;
   logic signed [X_W:0] w_dx;
   logic signed [Y_W:0] w_dy;
   logic signed [W-1:0] w_dxe;
   logic signed [W-1:0] w_dye;
   logic signed [W-1:0] w_xs;
   logic signed [W-1:0] w_ys;
   logic signed [W-1:0] w_xn;
   logic signed [W-1:0] w_yn;
   logic [ANGLE_W-1:0] w_zn;
   logic [ANGLE_W-1:0] w_at;

   assign w_frame_done = (hcount_in == 11'(FRAME_H)) &&
                         (vcount_in == 10'(FRAME_V));
   assign w_full_next  = (r_fill >= CW'(DEPTH - 1));

   assign w_dx  = {1'b0, r_hx[0]} - {1'b0, r_hx[DEPTH-1]};
   assign w_dy  = {1'b0, r_hy[0]} - {1'b0, r_hy[DEPTH-1]};
   assign w_dxe = {{2{w_dx[X_W]}}, w_dx};
   assign w_dye = {{(W-Y_W-1){w_dy[Y_W]}}, w_dy};

   assign w_xs = r_x >>> r_i;
   assign w_ys = r_y >>> r_i;
   assign w_at = atan_ang(int'(r_i));

   // Vectoring step: rotate towards y = 0, accumulating the rotation in z
   always_comb begin
      w_xn = r_x;
      w_yn = r_y;
      w_zn = r_z;
      if (!r_y[W-1]) begin
         w_xn = r_x + w_ys;
         w_yn = r_y - w_xs;
         w_zn = r_z + w_at;
      end else begin
         w_xn = r_x - w_ys;
         w_yn = r_y + w_xs;
         w_zn = r_z - w_at;
      end
   end

`ifdef SLICE_VECTOR_SWIPE_EN
   logic [W-1:0] r_mag;
   logic         r_swipe;
   logic [W-1:0] w_mag;
   assign w_mag     = r_zero ? '0 : $unsigned(w_xn);
   assign mag_out   = r_mag;
   assign swipe_out = r_swipe;
`else
   assign mag_out   = '0;
   assign swipe_out = 1'b0;
`endif

   always_ff @(posedge pixel_clk_in) begin
      if (!rst_n_in) begin
         for (int k = 0; k < DEPTH; k++) begin
            r_hx[k] <= '0;
            r_hy[k] <= '0;
         end
         r_fill  <= '0;
         r_state <= S_IDLE;
         r_i     <= '0;
         r_x     <= '0;
         r_y     <= '0;
         r_z     <= '0;
         r_zero  <= 1'b0;
         r_angle <= '0;
         r_valid <= 1'b0;
`ifdef SLICE_VECTOR_SWIPE_EN
         r_mag   <= '0;
         r_swipe <= 1'b0;
`endif
      end else begin
         r_valid <= 1'b0;
         if (w_frame_done) begin
            r_hx[0] <= katana_x;
            r_hy[0] <= katana_y;
            for (int k = 1; k < DEPTH; k++) begin
               r_hx[k] <= r_hx[k-1];
               r_hy[k] <= r_hy[k-1];
            end
            if (r_fill != CW'(DEPTH))
               r_fill <= r_fill + 1'b1;
         end
         // A new frame always wins: any running computation is dropped
         if (w_frame_done && w_full_next) begin
            r_state <= S_PREP;
         end else begin
            case (r_state)
               S_PREP: begin
                  r_zero  <= (w_dx == '0) && (w_dy == '0);
                  r_i     <= '0;
                  r_state <= S_ITER;
                  if (w_dx[X_W]) begin
                     r_x <= -w_dxe;
                     r_y <= -w_dye;
                     r_z <= {1'b1, {(ANGLE_W-1){1'b0}}};
                  end else begin
                     r_x <= w_dxe;
                     r_y <= w_dye;
                     r_z <= '0;
                  end
               end
               S_ITER: begin
                  r_x <= w_xn;
                  r_y <= w_yn;
                  r_z <= w_zn;
                  if (r_i == IW'(ITER - 1)) begin
                     r_angle <= r_zero ? '0 : w_zn;
                     r_valid <= 1'b1;
                     r_state <= S_IDLE;
`ifdef SLICE_VECTOR_SWIPE_EN
                     r_mag   <= w_mag;
                     r_swipe <= !r_zero && (w_mag >= W'(SWIPE_THRESH));
`endif
                  end else begin
                     r_i <= r_i + 1'b1;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign angle_out       = r_angle;
   assign angle_valid_out = r_valid;
   assign busy_out        = (r_state != S_IDLE);
   assign primed_out      = (r_fill == CW'(DEPTH));

endmodule

// File: tb/tb_slice_vector.sv
// tb_slice_vector: scoreboard bench for slice_vector.
// Expected headings come from a bench-side integer CORDIC model.
module tb_slice_vector;

   localparam int X_W          = 11;
   localparam int Y_W          = 10;
   localparam int DEPTH        = 10;
   localparam int ANGLE_W      = 16;
   localparam int ITER         = 12;
   localparam int FRAME_H      = 1024;
   localparam int FRAME_V      = 768;
   localparam int SWIPE_THRESH = 64;
   localparam int GAP          = 20;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [10:0]        hc = '0;
   logic [9:0]         vc = '0;
   logic [X_W-1:0]     kx = '0;
   logic [Y_W-1:0]     ky = '0;
   logic [ANGLE_W-1:0] angle;
   logic               valid;
   logic               busy;
   logic               primed;
   logic [X_W+2:0]     mag;
   logic               swipe;

   always #5 clk = ~clk;

   slice_vector #(
      .X_W(X_W), .Y_W(Y_W), .DEPTH(DEPTH), .ANGLE_W(ANGLE_W),
      .ITER(ITER), .FRAME_H(FRAME_H), .FRAME_V(FRAME_V),
      .SWIPE_THRESH(SWIPE_THRESH)
   ) dut (
      .pixel_clk_in(clk),
      .rst_n_in(rst_n),
      .hcount_in(hc),
      .vcount_in(vc),
      .katana_x(kx),
      .katana_y(ky),
      .angle_out(angle),
      .angle_valid_out(valid),
      .busy_out(busy),
      .primed_out(primed),
      .mag_out(mag),
      .swipe_out(swipe)
   );

   typedef struct {
      int ang;
      int mag;
      int sw;
      int t;
   } exp_t;

   exp_t sbq[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   int   nstrobe = 0;
   int   nexp = 0;
   int   last_ang = 0;
   int   hx[DEPTH];
   int   hy[DEPTH];
   int   fill = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string tag, longint got, longint exp);
      total++;
      if (got != exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic void cordic(input int dx, input int dy,
                                  output int ang, output int m);
      int x, y, z, xt, at;
      if (dx == 0 && dy == 0) begin
         ang = 0;
         m = 0;
         return;
      end
      if (dx < 0) begin
         x = -dx; y = -dy; z = 1 << (ANGLE_W - 1);
      end else begin
         x = dx; y = dy; z = 0;
      end
      for (int i = 0; i < ITER; i++) begin
         at = int'($floor($atan(1.0 / (2.0 ** i)) * (2.0 ** ANGLE_W)
                         / (2.0 * 3.14159265358979) + 0.5));
         xt = x;
         if (y >= 0) begin
            x = x + (y >>> i); y = y - (xt >>> i); z = z + at;
         end else begin
            x = x - (y >>> i); y = y + (xt >>> i); z = z - at;
         end
      end
      ang = z & ((1 << ANGLE_W) - 1);
      m = x;
   endfunction

   always @(negedge clk) begin
      if (rst_n && valid) begin
         nstrobe++;
         if (sbq.size() == 0) begin
            chk("spurious_strobe", 1, 0);
         end else begin
            exp_t e;
            e = sbq.pop_front();
            chk("strobe_time", cyc, e.t + ITER + 2);
            chk("angle", angle, e.ang);
            chk("mag", mag, e.mag);
            chk("swipe", swipe, e.sw);
            last_ang = e.ang;
         end
      end
   end

   task automatic do_reset(int n);
      @(negedge clk);
      rst_n = 1'b0;
      hc = '0;
      vc = '0;
      nexp -= sbq.size();
      sbq.delete();
      fill = 0;
      for (int k = 0; k < DEPTH; k++) begin
         hx[k] = 0;
         hy[k] = 0;
      end
      repeat (n) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Drive one frame_done with a katana sample, then idle to the next frame
   task automatic frame(int x, int y, int gap);
      int a, m;
      exp_t e;
      @(negedge clk);
      kx = X_W'(x);
      ky = Y_W'(y);
      hc = 11'(FRAME_H);
      vc = 10'(FRAME_V);
      if (sbq.size() > 0 && sbq[$].t + ITER + 2 > cyc) begin
         void'(sbq.pop_back());
         nexp--;
      end
      for (int k = DEPTH - 1; k > 0; k--) begin
         hx[k] = hx[k-1];
         hy[k] = hy[k-1];
      end
      hx[0] = x;
      hy[0] = y;
      if (fill < DEPTH) fill++;
      if (fill == DEPTH) begin
         cordic(hx[0] - hx[DEPTH-1], hy[0] - hy[DEPTH-1], a, m);
         e.ang = a;
         e.t = cyc;
`ifdef SLICE_VECTOR_SWIPE_EN
         e.mag = m;
         e.sw = (m >= SWIPE_THRESH) ? 1 : 0;
`else
         e.mag = 0;
         e.sw = 0;
`endif
         sbq.push_back(e);
         nexp++;
      end
      @(negedge clk);
      hc = '0;
      vc = '0;
      chk("primed", primed, (fill == DEPTH) ? 1 : 0);
      chk("busy", busy, (fill == DEPTH) ? 1 : 0);
      repeat (gap - 1) @(negedge clk);
   endtask

   task automatic seq(int x0, int y0, int sx, int sy);
      for (int k = 0; k < DEPTH; k++)
         frame(x0 + k * sx, y0 + k * sy, GAP);
   endtask

   initial begin
      do_reset(3);
      @(negedge clk);
      chk("rst_angle", angle, 0);
      chk("rst_valid", valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_primed", primed, 0);
      chk("rst_mag", mag, 0);
      chk("rst_swipe", swipe, 0);

      seq(100, 300, 10, 0);
      seq(500, 300, -10, 0);
      seq(400, 200, 0, 10);
      seq(300, 300, 5, 5);
      seq(300, 300, 5, -5);
      seq(600, 400, 0, 0);
      for (int k = 0; k < DEPTH - 1; k++) frame(100, 100, GAP);
      frame(120, 100, GAP);
      seq(0, 0, 227, 113);
      seq(2047, 1023, -227, -113);

      repeat (5) @(negedge clk);
      chk("hold_angle", angle, last_ang);

      // Reset in the middle of an iteration run
      frame(50, 60, 1);
      repeat (3) @(negedge clk);
      do_reset(1);
      chk("midrst_angle", angle, 0);
      chk("midrst_valid", valid, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_primed", primed, 0);
      chk("midrst_mag", mag, 0);
      chk("midrst_swipe", swipe, 0);
      repeat (GAP) @(negedge clk);
      seq(200, 100, 7, 3);

      // Back-to-back frames: the first run is abandoned
      frame(900, 500, 6);
      frame(950, 520, GAP);
      frame(800, 700, 3);
      frame(810, 690, GAP);

      repeat (GAP) @(negedge clk);
      chk("pending", sbq.size(), 0);
      chk("strobe_count", nstrobe, nexp);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
